// File: rtl/au_decode_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// au_decode_pipe_pkg : shared code-width helper and skid-buffer state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package au_decode_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // max(ceil(log2(x)), 1): a 1-entry space still needs a 1-bit code.
  function automatic int clogb2(input int x);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < x) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/au_skid_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// au_skid_buf : 2-entry valid/ready skid buffer with registered in_ready
// Revision: 1.0
// ---------------------------------------------------------------------------
module au_skid_buf
  import au_decode_pipe_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  buf_state_e    state;
  buf_state_e    state_next;
  logic [DW-1:0] main_reg;
  logic [DW-1:0] skid_reg;
  logic          ready_reg;
  logic          in_xfer;
  logic          out_xfer;
  logic          load_main;
  logic          load_skid;
  logic          skid_to_main;

  assign in_xfer  = in_valid & ready_reg;
  assign out_xfer = (state != EMPTY) & out_ready;

  always_comb begin
    state_next   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_next = ONE;
          load_main  = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // ready_reg is low here, so no input can arrive alongside the drain
        if (out_xfer) begin
          state_next   = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      ready_reg <= 1'b1;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state     <= state_next;
      ready_reg <= (state_next != TWO);
      if (load_main) begin
        main_reg <= in_data;
      end else if (skid_to_main) begin
        main_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= in_data;
      end
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_reg;

endmodule
`default_nettype wire

// File: rtl/au_decode_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// au_decode_pipe : streaming binary to one-hot / thermometer decoder
// Revision: 1.0
// ---------------------------------------------------------------------------
module au_decode_pipe
  import au_decode_pipe_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int THERMO = 0,
  localparam int M      = clogb2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             err_sticky,
  input  logic             err_clr
);

  logic [WIDTH-1:0] dec_data;
  logic             dec_err;
  logic [WIDTH:0]   buf_out;

  // Out-of-range codes decode to all zeros and are flagged alongside the beat.
  always_comb begin
    dec_data = '0;
    dec_err  = (32'(in_code) >= 32'(WIDTH));
    if (!dec_err) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (THERMO != 0) begin
          dec_data[i] = (32'(i) <= 32'(in_code));
        end else begin
          dec_data[i] = (32'(i) == 32'(in_code));
        end
      end
    end
  end

  au_skid_buf #(
    .DW (WIDTH + 1)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({dec_data, dec_err}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_data = buf_out[WIDTH:1];
  assign out_err  = buf_out[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (in_valid && in_ready && dec_err) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_au_decode_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_au_decode_pipe : directed and randomized checks of au_decode_pipe
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_au_decode_pipe;
  import au_decode_pipe_pkg::*;

  localparam int STRESS_BEATS = 3000;
  localparam int STRESS_LIMIT = 40000;
  localparam int SW[3] = '{1, 5, 16};
  localparam int ST[3] = '{0, 0, 1};
  localparam int TCODE[3] = '{3, 0, 7};
  localparam logic [7:0] TEXP[3] = '{8'h0F, 8'h01, 8'hFF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_decode(input int code, input int w, input int thermo);
    if (code >= w) return 64'd0;
    if (thermo != 0) return (64'd2 << code) - 64'd1;
    return 64'd1 << code;
  endfunction

  logic rst_n;
  logic rst_s_n;

  // a: WIDTH=8 one-hot, b: WIDTH=8 thermometer, c: WIDTH=5 one-hot
  logic       a_in_valid, a_out_ready, a_err_clr, a_in_ready, a_out_valid, a_out_err, a_err_sticky;
  logic [2:0] a_in_code;
  logic [7:0] a_out_data;
  logic       b_in_valid, b_out_ready, b_err_clr, b_in_ready, b_out_valid, b_out_err, b_err_sticky;
  logic [2:0] b_in_code;
  logic [7:0] b_out_data;
  logic       c_in_valid, c_out_ready, c_err_clr, c_in_ready, c_out_valid, c_out_err, c_err_sticky;
  logic [2:0] c_in_code;
  logic [4:0] c_out_data;

  au_decode_pipe #(.WIDTH(8), .THERMO(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_code(a_in_code), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_err(a_out_err), .err_sticky(a_err_sticky),
    .err_clr(a_err_clr)
  );

  au_decode_pipe #(.WIDTH(8), .THERMO(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_code(b_in_code), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_err(b_out_err), .err_sticky(b_err_sticky),
    .err_clr(b_err_clr)
  );

  au_decode_pipe #(.WIDTH(5), .THERMO(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_code(c_in_code), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_err(c_out_err), .err_sticky(c_err_sticky),
    .err_clr(c_err_clr)
  );

  bit stress_done[3];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_stress
      localparam int W  = SW[g];
      localparam int T  = ST[g];
      localparam int MW = clogb2(W);

      logic          in_valid = 1'b0;
      logic          out_ready = 1'b0;
      logic          err_clr = 1'b0;
      logic [MW-1:0] in_code = '0;
      logic          in_ready, out_valid, out_err, err_sticky;
      logic [W-1:0]  out_data;
      logic [63:0]   q_data[$];
      bit            q_err[$];

      au_decode_pipe #(.WIDTH(W), .THERMO(T)) u_dut (
        .clk(clk), .rst_n(rst_s_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .err_sticky(err_sticky),
        .err_clr(err_clr)
      );

      initial begin
        int popped;
        int cyc;
        int code;
        bit exp_sticky;
        bit in_x;
        bit out_x;
        popped = 0;
        cyc = 0;
        exp_sticky = 1'b0;
        repeat (4) @(negedge clk);
        while (popped < STRESS_BEATS && cyc < STRESS_LIMIT) begin
          @(negedge clk);
          cyc++;
          check($sformatf("w%0d_out_valid", W), 64'(out_valid), 64'(q_data.size() != 0));
          check($sformatf("w%0d_in_ready", W), 64'(in_ready), 64'(q_data.size() < 2));
          check($sformatf("w%0d_err_sticky", W), 64'(err_sticky), 64'(exp_sticky));
          if (q_data.size() != 0) begin
            check($sformatf("w%0d_out_data", W), 64'(out_data), q_data[0]);
            check($sformatf("w%0d_out_err", W), 64'(out_err), 64'(q_err[0]));
          end
          in_valid  = ($urandom_range(0, 1) == 1);
          out_ready = ($urandom_range(0, 1) == 1);
          err_clr   = ($urandom_range(0, 7) == 0);
          code      = int'($urandom_range(0, (1 << MW) - 1));
          in_code   = MW'(code);
          out_x = out_ready && (q_data.size() > 0);
          in_x  = in_valid && (q_data.size() < 2);
          if (out_x) begin
            void'(q_data.pop_front());
            void'(q_err.pop_front());
            popped++;
          end
          if (in_x) begin
            q_data.push_back(ref_decode(code, W, T));
            q_err.push_back(code >= W);
          end
          if (in_x && code >= W) exp_sticky = 1'b1;
          else if (err_clr) exp_sticky = 1'b0;
        end
        if (popped < STRESS_BEATS) begin
          check($sformatf("w%0d_stress_timeout", W), 64'(popped), 64'(STRESS_BEATS));
        end
        in_valid = 1'b0;
        stress_done[g] = 1'b1;
      end
    end
  endgenerate

  initial begin
    rst_n = 1'b0;
    rst_s_n = 1'b0;
    {a_in_valid, a_out_ready, a_err_clr} = 3'b000;
    {b_in_valid, b_out_ready, b_err_clr} = 3'b000;
    {c_in_valid, c_out_ready, c_err_clr} = 3'b000;
    a_in_code = '0;
    b_in_code = '0;
    c_in_code = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_out_data", 64'(a_out_data), 64'd0);
    check("rst_out_err", 64'(a_out_err), 64'd0);
    check("rst_err_sticky", 64'(a_err_sticky), 64'd0);
    rst_n = 1'b1;
    rst_s_n = 1'b1;

    // one-hot decode of every code at full rate
    a_out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check($sformatf("onehot_valid_%0d", k - 1), 64'(a_out_valid), 64'd1);
        check($sformatf("onehot_data_%0d", k - 1), 64'(a_out_data), 64'd1 << (k - 1));
        check($sformatf("onehot_ready_%0d", k - 1), 64'(a_in_ready), 64'd1);
      end
      if (k < 8) begin
        a_in_valid = 1'b1;
        a_in_code  = 3'(k);
      end else begin
        a_in_valid = 1'b0;
      end
    end

    b_out_ready = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check($sformatf("thermo_valid_%0d", TCODE[k - 1]), 64'(b_out_valid), 64'd1);
        check($sformatf("thermo_data_%0d", TCODE[k - 1]), 64'(b_out_data), 64'(TEXP[k - 1]));
      end
      if (k < 3) begin
        b_in_valid = 1'b1;
        b_in_code  = 3'(TCODE[k]);
      end else begin
        b_in_valid = 1'b0;
      end
    end

    // backpressure: fill both entries, then release
    @(negedge clk);
    check("bp_empty", 64'(a_out_valid), 64'd0);
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_code   = 3'd1;
    @(negedge clk);
    check("bp_ready_one", 64'(a_in_ready), 64'd1);
    check("bp_data_one", 64'(a_out_data), 64'h02);
    a_in_code = 3'd2;
    @(negedge clk);
    check("bp_ready_two", 64'(a_in_ready), 64'd0);
    check("bp_hold", 64'(a_out_data), 64'h02);
    a_in_code = 3'd3;
    @(negedge clk);
    check("bp_ready_two_b", 64'(a_in_ready), 64'd0);
    check("bp_hold_b", 64'(a_out_data), 64'h02);
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_second", 64'(a_out_data), 64'h04);
    check("bp_ready_back", 64'(a_in_ready), 64'd1);
    a_in_valid = 1'b0;
    @(negedge clk);
    check("bp_drained", 64'(a_out_valid), 64'd0);

    // asynchronous reset with two beats buffered
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_code   = 3'd5;
    @(negedge clk);
    a_in_code = 3'd6;
    @(negedge clk);
    check("rst_mid_full", 64'(a_in_ready), 64'd0);
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_mid_out_data", 64'(a_out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_in_valid  = 1'b1;
    a_in_code   = 3'd4;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("rst_after_valid", 64'(a_out_valid), 64'd1);
    check("rst_after_data", 64'(a_out_data), 64'h10);
    a_in_valid = 1'b0;

    // out-of-range codes on WIDTH=5
    c_out_ready = 1'b1;
    @(negedge clk);
    check("oor_sticky_init", 64'(c_err_sticky), 64'd0);
    c_in_valid = 1'b1;
    c_in_code  = 3'd4;
    @(negedge clk);
    check("oor_inrange_data", 64'(c_out_data), 64'h10);
    check("oor_inrange_err", 64'(c_out_err), 64'd0);
    check("oor_inrange_sticky", 64'(c_err_sticky), 64'd0);
    c_in_code = 3'd6;
    @(negedge clk);
    check("oor_data", 64'(c_out_data), 64'd0);
    check("oor_err", 64'(c_out_err), 64'd1);
    check("oor_sticky", 64'(c_err_sticky), 64'd1);
    c_in_valid = 1'b0;
    c_err_clr  = 1'b1;
    @(negedge clk);
    check("oor_cleared", 64'(c_err_sticky), 64'd0);
    c_in_valid = 1'b1;
    c_in_code  = 3'd7;
    @(negedge clk);
    check("oor_set_wins", 64'(c_err_sticky), 64'd1);
    check("oor_err_7", 64'(c_out_err), 64'd1);
    check("oor_data_7", 64'(c_out_data), 64'd0);
    c_in_valid = 1'b0;
    c_err_clr  = 1'b0;

    for (int c = 0; c < STRESS_LIMIT + 100; c++) begin
      if (stress_done[0] && stress_done[1] && stress_done[2]) break;
      @(negedge clk);
    end
    if (!(stress_done[0] && stress_done[1] && stress_done[2])) begin
      check("stress_done", 64'd0, 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
